// File: rtl/pwm_reg_scheduler.sv
// Round-robin register-write scheduler for the PWM configuration bank: two writers feed
// shadow registers that commit atomically to the active outputs, immediately or at the period wrap.
module pwm_reg_scheduler #(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    input  logic       sync_mode,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic [7:0] pwm_count,
    output logic       period_start,
    output logic       commit_pending,
    output logic       wr_err
);
    localparam int          DATA_W  = 8;
    localparam int          ADDR_W  = 7;
    localparam int          NREG    = 5;
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic              prefer_b;
    logic [15:0]       pre_cnt;
    logic              tick;
    logic              wrap;
    logic              commit;
    logic              wr_en;
    logic              wr_hit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              dirty;
    logic [DATA_W-1:0] shadow [NREG];
    logic [DATA_W-1:0] active [NREG];

    // A lone requester is granted at once; on contention the port not served last wins.
    assign a_ready = a_valid && (!b_valid || !prefer_b);
    assign b_ready = b_valid && (!a_valid || prefer_b);
    assign wr_en   = a_ready || b_ready;
    assign wr_addr = a_ready ? a_addr : b_addr;
    assign wr_data = a_ready ? a_data : b_data;
    assign wr_hit  = wr_en && (wr_addr < ADDR_W'(NREG));

    assign tick   = (pre_cnt == PRE_MAX);
    assign wrap   = tick && (pwm_count == 8'hFF);
    assign commit = dirty && (!sync_mode || wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_b <= 1'b0;
        end else if (wr_en) begin
            prefer_b <= a_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            pwm_count    <= '0;
            period_start <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + 16'd1;
            if (tick) begin
                pwm_count <= pwm_count + 8'd1;
            end
            period_start <= wrap;
            wr_err       <= wr_en && !wr_hit;
        end
    end

    // The commit copies the pre-edge shadow, so a write landing on the same edge stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_hit && (wr_addr == ADDR_W'(i))) begin
                    shadow[i] <= wr_data;
                end
                if (commit) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_hit) begin
                dirty <= 1'b1;
            end else if (commit) begin
                dirty <= 1'b0;
            end
        end
    end

    assign en_reg_out_7_0  = active[0];
    assign en_reg_out_15_8 = active[1];
    assign en_reg_pwm_7_0  = active[2];
    assign en_reg_pwm_15_8 = active[3];
    assign pwm_duty_cycle  = active[4];
    assign commit_pending  = dirty;

endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// Scoreboard bench for pwm_reg_scheduler: two instances (PRESCALE 1 and 2), each with its own
// driver, a reference model that predicts commits/errors into queues, and a monitor that pops them.
`timescale 1ns/1ps
module tb_pwm_reg_scheduler;

    typedef struct {
        logic [39:0] regs;
        int unsigned edge_n;
    } commit_ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done [2];

    task automatic chk(input int inst, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL inst%0d %s actual=0x%0h required=0x%0h t=%0t", inst, name, act, req, $time);
        end
    endtask

    task automatic miss(input int inst, input string name, input longint act, input longint req);
        checks++;
        failures++;
        $display("FAIL inst%0d %s actual=%0d required=%0d t=%0t", inst, name, act, req, $time);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int P      = g + 1;
        localparam int PERIOD = 256 * P;

        logic       rst_n;
        logic       a_valid, b_valid, sync_mode;
        logic       a_ready, b_ready;
        logic [6:0] a_addr, b_addr;
        logic [7:0] a_data, b_data;
        logic [7:0] r0, r1, r2, r3, r4, pwm_count;
        logic       period_start, commit_pending, wr_err;

        pwm_reg_scheduler #(.PRESCALE(P)) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .a_valid        (a_valid),
            .a_ready        (a_ready),
            .a_addr         (a_addr),
            .a_data         (a_data),
            .b_valid        (b_valid),
            .b_ready        (b_ready),
            .b_addr         (b_addr),
            .b_data         (b_data),
            .sync_mode      (sync_mode),
            .en_reg_out_7_0 (r0),
            .en_reg_out_15_8(r1),
            .en_reg_pwm_7_0 (r2),
            .en_reg_pwm_15_8(r3),
            .pwm_duty_cycle (r4),
            .pwm_count      (pwm_count),
            .period_start   (period_start),
            .commit_pending (commit_pending),
            .wr_err         (wr_err)
        );

        // Reference model: e counts clock edges since reset; period timing is pure arithmetic on e.
        int unsigned  e;
        bit           prefer_b;
        bit           dirty;
        logic [7:0]   shadow [5];
        logic [7:0]   active [5];
        commit_ev_t   cq [$];
        int unsigned  eq [$];

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e        = 0;
                prefer_b = 1'b0;
                dirty    = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    shadow[i] = 8'h00;
                    active[i] = 8'h00;
                end
                cq.delete();
                eq.delete();
            end else begin
                bit          ga, gb, at_wrap;
                logic [6:0]  ad;
                logic [7:0]  dt;
                logic [39:0] old_v, new_v;
                e++;
                ga      = a_valid && (!b_valid || !prefer_b);
                gb      = b_valid && !ga;
                at_wrap = (e % PERIOD) == 0;
                if (dirty && (!sync_mode || at_wrap)) begin
                    old_v = {active[4], active[3], active[2], active[1], active[0]};
                    new_v = {shadow[4], shadow[3], shadow[2], shadow[1], shadow[0]};
                    if (new_v != old_v) cq.push_back('{regs: new_v, edge_n: e});
                    for (int i = 0; i < 5; i++) active[i] = shadow[i];
                    dirty = 1'b0;
                end
                if (ga || gb) begin
                    ad       = ga ? a_addr : b_addr;
                    dt       = ga ? a_data : b_data;
                    prefer_b = ga;
                    if (ad <= 7'd4) begin
                        for (int i = 0; i < 5; i++) if (int'(ad) == i) shadow[i] = dt;
                        dirty = 1'b1;
                    end else begin
                        eq.push_back(e);
                    end
                end
            end
        end

        logic [39:0] last_seen;

        always @(negedge clk) begin
            if (!rst_n) begin
                last_seen = '0;
            end else begin
                logic [39:0] now_v;
                commit_ev_t  ev;
                bit          exp_a;
                now_v = {r4, r3, r2, r1, r0};
                exp_a = a_valid && (!b_valid || !prefer_b);
                chk(g, "pwm_count", pwm_count, 64'((e / P) % 256));
                chk(g, "period_start", period_start, 64'((e != 0) && (e % PERIOD == 0)));
                chk(g, "commit_pending", commit_pending, 64'(dirty));
                chk(g, "grant", {a_ready, b_ready}, {exp_a, b_valid && !exp_a});
                while (cq.size() != 0 && cq[0].edge_n < e) begin
                    miss(g, "commit_overdue_edge", e, cq[0].edge_n);
                    void'(cq.pop_front());
                end
                if (now_v != last_seen) begin
                    if (cq.size() == 0) begin
                        miss(g, "unexpected_commit_edge", e, -1);
                    end else begin
                        ev = cq.pop_front();
                        chk(g, "commit_value", now_v, ev.regs);
                        chk(g, "commit_edge", e, ev.edge_n);
                    end
                end
                last_seen = now_v;
                while (eq.size() != 0 && eq[0] < e) begin
                    miss(g, "wr_err_overdue_edge", e, eq[0]);
                    void'(eq.pop_front());
                end
                if (wr_err) begin
                    if (eq.size() == 0) miss(g, "unexpected_wr_err_edge", e, -1);
                    else chk(g, "wr_err_edge", e, eq.pop_front());
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic wr(input bit port_b, input logic [6:0] ad, input logic [7:0] dt);
            int tries;
            bit acc;
            tries = 0;
            acc   = 1'b0;
            if (port_b) begin
                b_valid = 1'b1; b_addr = ad; b_data = dt;
            end else begin
                a_valid = 1'b1; a_addr = ad; a_data = dt;
            end
            while (!acc && tries < 8) begin
                @(negedge clk);
                acc = port_b ? b_ready : a_ready;
                @(posedge clk);
                #1;
                tries++;
            end
            if (port_b) b_valid = 1'b0; else a_valid = 1'b0;
            chk(g, "wr_accepted", acc, 1);
        endtask

        initial begin
            int guard;
            rst_n = 1'b1; sync_mode = 1'b0;
            a_valid = 1'b0; a_addr = '0; a_data = '0;
            b_valid = 1'b0; b_addr = '0; b_data = '0;
            #1 rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;

            // Reset mid-period with a pending write
            sync_mode = 1'b1;
            repeat (37) step();
            wr(1'b0, 7'd2, 8'h5A);
            repeat (5) step();
            chk(g, "dirty_before_reset", commit_pending, 1);
            #2 rst_n = 1'b0;
            #1;
            chk(g, "reset_outputs", {r4, r3, r2, r1, r0, pwm_count, period_start, commit_pending, wr_err}, 0);
            @(posedge clk);
            #1 rst_n = 1'b1;
            sync_mode = 1'b0;
            a_valid = 1'b1;
            #1 chk(g, "a_ready_after_reset", a_ready, 1);
            a_valid = 1'b0;

            // Immediate commit
            wr(1'b0, 7'd4, 8'h80);
            chk(g, "pending_after_accept", commit_pending, 1);
            step();
            chk(g, "duty_committed", r4, 8'h80);
            chk(g, "others_zero", {r3, r2, r1, r0}, 0);
            chk(g, "pending_cleared", commit_pending, 0);

            // Invalid address
            wr(1'b1, 7'd9, 8'hFF);
            chk(g, "wr_err_high", wr_err, 1);
            step();
            chk(g, "wr_err_low", wr_err, 0);
            chk(g, "regs_after_bad_addr", {r4, r3, r2, r1, r0}, {8'h80, 32'h0});
            chk(g, "pending_after_bad_addr", commit_pending, 0);

            // Round-robin with both ports valid
            a_valid = 1'b1; a_addr = 7'd1; a_data = 8'h11;
            b_valid = 1'b1; b_addr = 7'd2; b_data = 8'h22;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk(g, "rr_order", {a_ready, b_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
                @(posedge clk);
                #1;
            end
            a_valid = 1'b0; b_valid = 1'b0;
            step();
            chk(g, "rr_reg1", r1, 8'h11);
            chk(g, "rr_reg2", r2, 8'h22);

            // Boundary commit
            sync_mode = 1'b1;
            guard = 0;
            while (pwm_count != 8'd10 && guard < PERIOD + 8) begin step(); guard++; end
            wr(1'b0, 7'd0, 8'hA5);
            chk(g, "sync_held_reg0", r0, 8'h00);
            chk(g, "sync_pending", commit_pending, 1);
            guard = 0;
            while (!period_start && guard < PERIOD + 8) begin step(); guard++; end
            chk(g, "wrap_period_start", period_start, 1);
            chk(g, "wrap_reg0", r0, 8'hA5);
            chk(g, "wrap_pending", commit_pending, 0);
            chk(g, "wrap_count", pwm_count, 8'h00);

            // Write landing on the wrap edge
            sync_mode = 1'b0;
            wr(1'b0, 7'd3, 8'h11);
            step();
            chk(g, "pre_wrap_reg3", r3, 8'h11);
            sync_mode = 1'b1;
            wr(1'b0, 7'd2, 8'h77);
            guard = 0;
            while (((e + 1) % PERIOD) != 0 && guard < PERIOD + 8) begin step(); guard++; end
            a_valid = 1'b1; a_addr = 7'd3; a_data = 8'h3C;
            step();
            a_valid = 1'b0;
            chk(g, "on_wrap_edge", period_start, 1);
            chk(g, "on_wrap_reg2", r2, 8'h77);
            chk(g, "on_wrap_reg3_old", r3, 8'h11);
            chk(g, "on_wrap_pending", commit_pending, 1);
            repeat (PERIOD - 1) step();
            chk(g, "late_reg3_old", r3, 8'h11);
            step();
            chk(g, "late_reg3_new", r3, 8'h3C);
            chk(g, "late_pending", commit_pending, 0);

            // Randomized traffic
            for (int i = 0; i < 1500; i++) begin
                a_valid = ($urandom_range(0, 2) != 0);
                b_valid = ($urandom_range(0, 2) != 0);
                a_addr  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
                b_addr  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
                a_data  = 8'($urandom);
                b_data  = 8'($urandom);
                if ($urandom_range(0, 63) == 0) sync_mode = ~sync_mode;
                if ($urandom_range(0, 499) == 0) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    #1 rst_n = 1'b1;
                end
                step();
            end
            a_valid = 1'b0; b_valid = 1'b0; sync_mode = 1'b0;
            repeat (4) step();
            chk(g, "commit_queue_drained", cq.size(), 0);
            chk(g, "err_queue_drained", eq.size(), 0);
            done[g] = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(done[0] && done[1]) && t < 90000) begin
            @(posedge clk);
            t++;
        end
        if (!(done[0] && done[1])) miss(0, "run_timeout_cycles", t, 90000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_reg_scheduler.md
# pwm_reg_scheduler

Register-write scheduler for the PWM configuration bank (output enables, PWM enables, duty cycle). It arbitrates round-robin between two write requesters, port A (SPI peripheral) and port B (on-chip auxiliary sequencer), and holds the writes in shadow registers. It commits the shadow registers atomically to the active outputs, either immediately or at the next PWM period boundary. It also owns the 8-bit PWM period counter that the PWM output stage consumes.

## Interface

**Parameters**
- `PRESCALE`, default 1: clk cycles per PWM count step. Legal range is 1..65535.

**Ports**
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `a_valid` input 1: port A write request.
- `a_ready` output 1: port A grant. Combinational.
- `a_addr` input 7: port A register address.
- `a_data` input 8: port A write data.
- `b_valid` input 1: port B write request.
- `b_ready` output 1: port B grant. Combinational.
- `b_addr` input 7: port B register address.
- `b_data` input 8: port B write data.
- `sync_mode` input 1: commit mode. 0 = commit on the next clk edge; 1 = commit at the period boundary.
- `en_reg_out_7_0` output 8: active register, address 0.
- `en_reg_out_15_8` output 8: active register, address 1.
- `en_reg_pwm_7_0` output 8: active register, address 2.
- `en_reg_pwm_15_8` output 8: active register, address 3.
- `pwm_duty_cycle` output 8: active register, address 4.
- `pwm_count` output 8: PWM period counter.
- `period_start` output 1: one-cycle pulse when `pwm_count` wraps.
- `commit_pending` output 1: shadow registers differ from active (dirty flag).
- `wr_err` output 1: one-cycle pulse after an accepted write to an address above 4.

## Operation

**Arbitration**
- A transfer occurs when `x_valid && x_ready` at a clk edge. At most one write is accepted per cycle.
- With one valid, that port is granted in the same cycle.
- With both valid, the port not granted last is granted.
- After reset the preference pointer favours A.
- The pointer updates only on an actual transfer.
- `x_ready` is never high without the matching `x_valid`.

**Shadow write**
- Addresses 0..4: the addressed shadow register takes the data, and `dirty` is set.
- Other shadow registers keep their values. This is a partial update; unaddressed registers are not zeroed.
- Addresses 5..127: the data is discarded, `dirty` is not touched, and `wr_err` pulses high for the cycle after the accepting edge.

**Prescaler and counter**
- `pre_cnt` counts 0..PRESCALE-1. `tick` is high when `pre_cnt == PRESCALE-1`.
- On `tick`, `pwm_count` increments modulo 256.
- Wrap edge: the edge where `tick` is high and `pwm_count == 255`.
- `period_start` is registered. It is high during the first cycle in which `pwm_count == 0` after a wrap.

**Commit**
- `sync_mode=0`: on any edge where `dirty=1`, active <= shadow and `dirty` clears.
- `sync_mode=1`: commit happens only on a wrap edge with `dirty=1`.
- All five active registers update on the same edge. Partial commits never occur.
- A write accepted on a commit edge is not included in that commit: active takes the pre-write shadow value, and `dirty` stays 1 (the write wins over the clear).
- Toggling `sync_mode` 1→0 while `dirty=1` commits on the next edge.
- `commit_pending` equals `dirty`.

**Reset**
- Asynchronous. Takes effect mid-transfer or mid-period.
- Clears all shadow and active registers, `pwm_count`, `pre_cnt`, `dirty`, `period_start`, `wr_err` to 0, and sets the round-robin pointer to A.
- Pending shadow writes are lost.

## Timing

- Reset values: every output is 0. `a_ready`/`b_ready` follow `a_valid`/`b_valid` combinationally.
- Write-to-output latency with `sync_mode=0`: the write is accepted at edge N and the active output changes at edge N+1.
- Latency with `sync_mode=1`: the output changes at the first wrap edge after the accepting edge. Worst case is 256·PRESCALE clk cycles.
- PWM period is 256·PRESCALE clk cycles. `period_start` spacing equals the period exactly.
- `wr_err` pulse: one cycle, registered, starting one cycle after the accept.
- Sustained throughput: one write per clk. With both ports continuously valid, grants strictly alternate.

## Test plan

1. **Reset.** Assert `rst_n=0` mid-period with `dirty=1`, then release. Required: all outputs 0, `commit_pending=0`; `a_ready=1` in the first cycle that `a_valid=1`.
2. **Immediate commit.** With `sync_mode=0`, port A writes addr 4, data 0x80. Required: `pwm_duty_cycle=0x80` one cycle after the accept; the other four registers stay 0; `commit_pending` is high for exactly 1 cycle.
3. **Boundary commit.** With `sync_mode=1` and PRESCALE=1, write addr 0, data 0xA5 at `pwm_count=10`. Required: `en_reg_out_7_0` stays 0 and `commit_pending=1` until `pwm_count` wraps 255→0. At the wrap, `en_reg_out_7_0=0xA5`, `period_start=1`, `commit_pending=0`.
4. **Round-robin.** Hold both ports valid for 4 cycles (A: addr1/0x11, B: addr2/0x22). Required: grant order A,B,A,B. After commit, `en_reg_out_15_8=0x11` and `en_reg_pwm_7_0=0x22`.
5. **Invalid address.** Port B writes addr 9, data 0xFF. Required: `wr_err` pulses high for exactly 1 cycle; all registers unchanged; `commit_pending` stays 0.
6. **Write on the wrap edge.** With `sync_mode=1` and PRESCALE=2, port A writes addr 3, data 0x3C on the wrap edge. Required: `en_reg_pwm_15_8` stays at its old value and `commit_pending` stays 1. It becomes 0x3C exactly 512 clk cycles later.
